// File: rtl/ascii_char_feeder_if.sv
// Byte-stream handshake between a raw source and ascii_char_feeder.
interface ascii_char_feeder_if;
  logic [7:0] in_byte;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_byte, output in_valid, input in_ready);
  modport slave  (input in_byte, input in_valid, output in_ready);
endinterface

// File: rtl/ascii_char_feeder.sv
// Filters and normalises a raw byte stream, buffers it, and replays it to the
// parser as fixed-shape char_valid / stmt_end pulses.
module ascii_char_feeder #(
  parameter int DEPTH = 8,
  parameter int HOLD  = 2,
  parameter int GAP   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  ascii_char_feeder_if.slave       in_if,
  output logic [6:0]               ascii_char,
  output logic                     char_valid,
  output logic                     stmt_end,
  output logic                     drop_flag,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CMAX  = (HOLD > GAP) ? HOLD : GAP;
  localparam int CNT_W = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_GAP} state_t;

  // Result layout: {store, drop, tag, char[6:0]}
  function automatic logic [9:0] classify_byte(input logic [7:0] b);
    if (b == 8'h20 || b == 8'h09 || b == 8'h0D)
      return 10'b0;
    else if (b == 8'h0A || b == 8'h3B)
      return {2'b10, 1'b1, 7'h00};
    else if (b[7] || b < 8'h20 || b == 8'h7F)
      return {2'b01, 8'h00};
    else if (b >= 8'h41 && b <= 8'h5A)
      return {2'b10, 1'b0, b[6:0] + 7'h20};
    else
      return {2'b10, 1'b0, b[6:0]};
  endfunction

  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic [9:0]      cls;
  logic            accept, push, pop;
  logic [7:0]      head;

  state_t          state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [6:0]      char_n;
  logic            cv_n, se_n;

  assign in_if.in_ready = !rst && (count != (AW+1)'(DEPTH));
  assign accept     = in_if.in_valid && in_if.in_ready;
  assign cls        = classify_byte(in_if.in_byte);
  assign push       = accept && cls[9];
  assign head       = mem[rd_ptr];
  assign fifo_count = count;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cls[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      drop_flag <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (accept && cls[8]) drop_flag <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      ascii_char <= '0;
      char_valid <= 1'b0;
      stmt_end   <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      ascii_char <= char_n;
      char_valid <= cv_n;
      stmt_end   <= se_n;
    end
  end

  // Output pulse shaper: stmt_end is always a single cycle, char_valid lasts HOLD cycles
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    char_n  = ascii_char;
    cv_n    = char_valid;
    se_n    = 1'b0;
    pop     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (count != '0) begin
          pop = 1'b1;
          if (head[7]) begin
            se_n = 1'b1;
            if (GAP == 0) begin
              state_n = S_IDLE;
            end else begin
              state_n = S_GAP;
              cnt_n   = GAP_LD;
            end
          end else begin
            char_n  = head[6:0];
            cv_n    = 1'b1;
            cnt_n   = HOLD_LD;
            state_n = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (cnt == '0) begin
          cv_n = 1'b0;
          if (GAP == 0) begin
            state_n = S_IDLE;
          end else begin
            state_n = S_GAP;
            cnt_n   = GAP_LD;
          end
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      S_GAP: begin
        if (cnt == '0) state_n = S_IDLE;
        else           cnt_n   = cnt - CNT_W'(1);
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ascii_char_feeder.sv
// Directed bench for ascii_char_feeder with default parameters (DEPTH=8, HOLD=2, GAP=1).
module tb_ascii_char_feeder;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] ascii_char;
  logic       char_valid, stmt_end, drop_flag;
  logic [3:0] fifo_count;

  ascii_char_feeder_if bus ();

  ascii_char_feeder #(.DEPTH(8), .HOLD(2), .GAP(1)) dut (
    .clk(clk), .rst(rst), .in_if(bus.slave),
    .ascii_char(ascii_char), .char_valid(char_valid), .stmt_end(stmt_end),
    .drop_flag(drop_flag), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output log: characters as their code, a stmt_end pulse as 256
  int ev_q[$], rise_q[$], len_q[$], se_q[$];
  int cv_run = 0, se_err = 0, ovl_err = 0, rdy_err = 0, max_cnt = 0, saw_full = 0;
  logic cv_prev = 1'b0, se_prev = 1'b0;
  int last_acc = 0;

  always @(negedge clk) begin
    if (char_valid && !cv_prev) begin
      ev_q.push_back(int'(ascii_char));
      rise_q.push_back(cyc);
    end
    if (!char_valid && cv_prev) len_q.push_back(cv_run);
    cv_run = char_valid ? cv_run + 1 : 0;
    if (stmt_end) begin
      ev_q.push_back(256);
      se_q.push_back(cyc);
      if (se_prev) se_err++;
    end
    if (char_valid && stmt_end) ovl_err++;
    if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
    if (fifo_count == 4'd8) saw_full = 1;
    if (fifo_count == 4'd8 && bus.in_ready) rdy_err++;
    if (fifo_count < 4'd8 && !rst && !bus.in_ready) rdy_err++;
    cv_prev = char_valid;
    se_prev = stmt_end;
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    #1;
    ev_q.delete(); rise_q.delete(); len_q.delete(); se_q.delete();
    se_err = 0; ovl_err = 0; rdy_err = 0; max_cnt = 0; saw_full = 0;
  endtask

  // Leaves in_valid high so consecutive calls stream one byte per cycle
  task automatic send(input logic [7:0] b);
    int n = 0;
    bus.in_byte  = b;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("send_timeout", int'(n < 100), 1);
    last_acc = cyc + 1;
    @(negedge clk);
  endtask

  task automatic send_str(input string s, output int first_acc);
    first_acc = 0;
    for (int i = 0; i < s.len(); i++) begin
      send(s[i]);
      if (i == 0) first_acc = last_acc;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((fifo_count != 0 || char_valid || stmt_end) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", int'(n < 300), 1);
    repeat (6) @(negedge clk);
  endtask

  // '$' in the expected string stands for a stmt_end pulse
  task automatic check_seq(input string tag, input string s);
    check({tag, "_count"}, ev_q.size(), s.len());
    for (int i = 0; i < s.len() && i < ev_q.size(); i++)
      check($sformatf("%s_ev%0d", tag, i), ev_q[i], (s[i] == "$") ? 256 : int'(s[i]));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  int acc;

  initial begin
    bus.in_byte  = 8'h00;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("rst_in_ready", int'(bus.in_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", int'(bus.in_ready), 1);
    check("idle_fifo_count", int'(fifo_count), 0);
    check("idle_char_valid", int'(char_valid), 0);
    check("idle_stmt_end", int'(stmt_end), 0);
    check("idle_ascii_char", int'(ascii_char), 0);
    check("idle_drop_flag", int'(drop_flag), 0);

    // Basic stream
    clear_logs();
    send_str("IF x==10", acc);
    drain();
    check_seq("basic", "ifx==10");
    if (rise_q.size() > 0) check("basic_latency", rise_q[0] - acc, 1);
    for (int i = 0; i < len_q.size(); i++) check($sformatf("basic_len%0d", i), len_q[i], 2);
    for (int i = 1; i < rise_q.size(); i++)
      check($sformatf("basic_period%0d", i), rise_q[i] - rise_q[i-1], 4);
    check("basic_drop", int'(drop_flag), 0);

    // Terminator
    clear_logs();
    send_str("p<=20;e", acc);
    drain();
    check_seq("term", "p<=20$e");
    check("term_se_count", se_q.size(), 1);
    check("term_se_width", se_err, 0);
    check("term_overlap", ovl_err, 0);
    if (se_q.size() == 1 && rise_q.size() == 6) begin
      check("term_se_after_0", se_q[0] - rise_q[4], 4);
      check("term_e_after_se", rise_q[5] - se_q[0], 2);
    end

    // Illegal bytes
    do_reset();
    clear_logs();
    send(8'h41);
    check("ill_drop_before", int'(drop_flag), 0);
    send(8'h07);
    check("ill_drop_on_07", int'(drop_flag), 1);
    send(8'hC1);
    send(8'h62);
    bus.in_valid = 1'b0;
    drain();
    check_seq("ill", "ab");
    check("ill_drop_sticky", int'(drop_flag), 1);

    // Whitespace, newline marker, DEL
    do_reset();
    check("ws_drop_cleared", int'(drop_flag), 0);
    clear_logs();
    send(8'h09); send(8'h5A); send(8'h0D); send(8'h0A);
    check("ws_drop_none", int'(drop_flag), 0);
    send(8'h7F);
    bus.in_valid = 1'b0;
    drain();
    check_seq("ws", "z$");
    check("ws_drop_7f", int'(drop_flag), 1);

    // Back-pressure
    do_reset();
    clear_logs();
    send_str("abcdefghijkl", acc);
    drain();
    check_seq("bp", "abcdefghijkl");
    check("bp_saw_full", saw_full, 1);
    check("bp_max_count", max_cnt, 8);
    check("bp_ready_rule", rdy_err, 0);
    check("bp_final_count", int'(fifo_count), 0);

    // Reset during the second cycle of the 'n' pulse with 5 entries queued
    do_reset();
    clear_logs();
    for (int i = 0; i < 7; i++) send(8'h6D + 8'(i));
    check("rm_pre_count", int'(fifo_count), 5);
    check("rm_pre_cv", int'(char_valid), 1);
    check("rm_pre_char", int'(ascii_char), int'("n"));
    check_seq("rm_pre", "mn");
    rst = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("rm_cv_cleared", int'(char_valid), 0);
    check("rm_count_cleared", int'(fifo_count), 0);
    check("rm_ready_in_rst", int'(bus.in_ready), 0);
    check("rm_char_cleared", int'(ascii_char), 0);
    rst = 1'b0;
    clear_logs();
    repeat (30) @(negedge clk);
    check("rm_no_stale", ev_q.size(), 0);
    check("rm_ready_after", int'(bus.in_ready), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
